move_sequencer: RTL
===================

// Module: move_sequencer
// PURPOSE
//  Sequences the dog toy's movement program and drives the 3-bit movement code to the
//  7-segment movement display decoder. Runs a fixed 5-step routine with timed dwell per step.
//  On an obstacle it inserts a back-off/turn manoeuvre, then resumes the routine.
//  Sits between user controls / obstacle sensor and the display decoder.
// PARAMETERS
//  TICK_DIV       50_000_000  clk cycles per movement tick (>=2)
//  DWELL_TICKS    3           ticks spent in each routine step and in TURN (>=1)
//  BACKOFF_TICKS  2           ticks spent reversing after an obstacle (>=1)
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst_n          in   1  asynchronous active-low reset
//  start          in   1  1-cycle pulse: begin routine (ignored unless IDLE)
//  stop           in   1  1-cycle pulse: abort to IDLE from any state
//  obstacle       in   1  async sensor level, high = obstacle ahead
//  move_code      out  3  movement code; [2] is MSB, wires to decoder bit0, [0] to bit2
//  busy           out  1  high in RUN/BACKOFF/TURN
//  done           out  1  1-cycle pulse on normal routine completion
//  obstacle_seen  out  1  sticky: set on any BACKOFF entry, cleared by accepted start
// BEHAVIOUR
//  Codes: 000 STOPPED, 001 FORWARD, 010 LEFT, 011 RIGHT, 100 REVERSE, 101 SIT.
//  Reset (async, rst_n=0): state IDLE, move_code=000, busy=0, done=0, obstacle_seen=0,
//   prescaler, tick counter, step index, sync/edge regs all 0.
//  All outputs registered; they change on the edge that changes state.
//  Routine: step 0..4 = FORWARD, LEFT, FORWARD, RIGHT, SIT.
//  Prescaler: counts 0..TICK_DIV-1, tick when at TICK_DIV-1, then wraps to 0. Prescaler and
//   tick counter clear on every state entry and every step advance, so each dwell is exactly
//   N_TICKS*TICK_DIV cycles.
//  Obstacle: 2-FF synchroniser then rising-edge detect (obs_rise). Edge reg resets to 0.
//  FSM:
//   IDLE:    move_code=000. start & !stop -> RUN, step=0, clear obstacle_seen.
//   RUN:     move_code=step code. stop -> IDLE. else obs_rise -> BACKOFF (step held,
//            obstacle_seen=1). else DWELL_TICKS-th tick: step<4 -> step+1; step==4 -> IDLE
//            with done=1 for that one cycle.
//   BACKOFF: move_code=100. stop -> IDLE. after BACKOFF_TICKS ticks -> TURN.
//   TURN:    move_code=011. stop -> IDLE. after DWELL_TICKS ticks -> RUN at held step,
//            full dwell restarted.
//  obs_rise in BACKOFF, TURN or IDLE: ignored (not queued).
//  obs_rise and last-tick in same RUN cycle: obstacle wins, step not advanced.
//  stop has priority over start, obstacle and tick in the same cycle; stop never pulses done.
//  start while busy: ignored. Obstacle level already high at start: no trigger until it
//   falls and rises again.
//  Latency: start at edge N -> move_code=001, busy=1 after edge N. Obstacle pin rise ->
//   BACKOFF 3 edges later (2 sync + edge-detect register).
//  Reset mid-operation: outputs return to reset values immediately, no clock required.
// TESTING  (TICK_DIV=4, DWELL_TICKS=3, BACKOFF_TICKS=2: step=12 cycles, backoff=8)
//  1 Assert rst_n=0 with no clock -> move_code=000, busy=0, done=0, obstacle_seen=0.
//  2 start pulse -> 001,010,001,011,101 each 12 cycles (busy 60 cycles); then done=1 for 1
//    cycle, move_code=000, busy=0.
//  3 obstacle rise 5 cycles into step 1 (010) -> 3 cycles later 100 for 8 cycles, 011 for 12,
//    then 010 for full 12; obstacle_seen=1; routine completes with done pulse.
//  4 stop pulse during TURN -> next edge move_code=000, busy=0, done stays 0; next start
//    clears obstacle_seen and begins at 001.
//  5 start+stop same cycle in IDLE -> stays IDLE; start pulse during RUN -> no restart,
//    step timing unchanged.
//  6 rst_n=0 mid-BACKOFF for 1/3 cycle then released -> outputs 000/0 immediately; no
//    activity until a new start.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: runs the dog toy's fixed five-step movement routine with a timed
// dwell per step, inserts a reverse/turn manoeuvre when an obstacle appears, and
// drives the 3-bit movement code to the display decoder. All outputs are registered.
module move_sequencer #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int DWELL_TICKS   = 3,
  parameter int BACKOFF_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       obstacle,
  output logic [2:0] move_code,
  output logic       busy,
  output logic       done,
  output logic       obstacle_seen
);

  localparam int PRE_W     = $clog2(TICK_DIV);
  localparam int MAX_TICKS = (DWELL_TICKS > BACKOFF_TICKS) ? DWELL_TICKS : BACKOFF_TICKS;
  localparam int TCNT_W    = $clog2(MAX_TICKS + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] DWELL_LAST   = TCNT_W'(DWELL_TICKS - 1);
  localparam logic [TCNT_W-1:0] BACKOFF_LAST = TCNT_W'(BACKOFF_TICKS - 1);
  localparam logic [2:0]        LAST_STEP    = 3'd4;

  localparam logic [2:0] CODE_STOPPED = 3'b000;
  localparam logic [2:0] CODE_FORWARD = 3'b001;
  localparam logic [2:0] CODE_LEFT    = 3'b010;
  localparam logic [2:0] CODE_RIGHT   = 3'b011;
  localparam logic [2:0] CODE_REVERSE = 3'b100;
  localparam logic [2:0] CODE_SIT     = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BACKOFF = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t              state_reg;
  logic [2:0]          step_reg;
  logic [PRE_W-1:0]    pre_reg;
  logic [TCNT_W-1:0]   tcnt_reg;
  logic [1:0]          obs_sync_reg;
  logic                obs_prev_reg;
  logic                obs_rise;
  logic                tick;

  // Routine table: FORWARD, LEFT, FORWARD, RIGHT, SIT.
  function automatic logic [2:0] step_code(input logic [2:0] s);
    case (s)
      3'd0:    step_code = CODE_FORWARD;
      3'd1:    step_code = CODE_LEFT;
      3'd2:    step_code = CODE_FORWARD;
      3'd3:    step_code = CODE_RIGHT;
      3'd4:    step_code = CODE_SIT;
      default: step_code = CODE_STOPPED;
    endcase
  endfunction

  // Two-flop synchroniser for the sensor level plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_sync_reg <= 2'b00;
      obs_prev_reg <= 1'b0;
    end else begin
      obs_sync_reg <= {obs_sync_reg[0], obstacle};
      obs_prev_reg <= obs_sync_reg[1];
    end
  end

  assign obs_rise = obs_sync_reg[1] & ~obs_prev_reg;
  assign tick     = (pre_reg == PRE_LAST);

  // Sequencer FSM with its timebase; every state entry or step advance restarts the dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      step_reg      <= 3'd0;
      pre_reg       <= '0;
      tcnt_reg      <= '0;
      move_code     <= CODE_STOPPED;
      busy          <= 1'b0;
      done          <= 1'b0;
      obstacle_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        pre_reg  <= '0;
        tcnt_reg <= tcnt_reg + TCNT_W'(1);
      end else begin
        pre_reg  <= pre_reg + PRE_W'(1);
      end

      case (state_reg)
        IDLE: begin
          pre_reg  <= '0;
          tcnt_reg <= '0;
          if (start && !stop) begin
            state_reg     <= RUN;
            step_reg      <= 3'd0;
            move_code     <= CODE_FORWARD;
            busy          <= 1'b1;
            obstacle_seen <= 1'b0;
          end
        end

        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            pre_reg   <= '0;
            tcnt_reg  <= '0;
            move_code <= CODE_STOPPED;
            busy      <= 1'b0;
          end else if (obs_rise) begin
            // Obstacle beats a coincident last tick: the step is held, not advanced.
            state_reg     <= BACKOFF;
            pre_reg       <= '0;
            tcnt_reg      <= '0;
            move_code     <= CODE_REVERSE;
            obstacle_seen <= 1'b1;
          end else if (tick && (tcnt_reg == DWELL_LAST)) begin
            pre_reg  <= '0;
            tcnt_reg <= '0;
            if (step_reg == LAST_STEP) begin
              state_reg <= IDLE;
              step_reg  <= 3'd0;
              move_code <= CODE_STOPPED;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              step_reg  <= step_reg + 3'd1;
              move_code <= step_code(step_reg + 3'd1);
            end
          end
        end

        BACKOFF: begin
          if (stop) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            pre_reg   <= '0;
            tcnt_reg  <= '0;
            move_code <= CODE_STOPPED;
            busy      <= 1'b0;
          end else if (tick && (tcnt_reg == BACKOFF_LAST)) begin
            state_reg <= TURN;
            pre_reg   <= '0;
            tcnt_reg  <= '0;
            move_code <= CODE_RIGHT;
          end
        end

        TURN: begin
          if (stop) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            pre_reg   <= '0;
            tcnt_reg  <= '0;
            move_code <= CODE_STOPPED;
            busy      <= 1'b0;
          end else if (tick && (tcnt_reg == DWELL_LAST)) begin
            // Resume the interrupted step with a full dwell.
            state_reg <= RUN;
            pre_reg   <= '0;
            tcnt_reg  <= '0;
            move_code <= step_code(step_reg);
          end
        end

        default: begin
          state_reg <= IDLE;
          step_reg  <= 3'd0;
          pre_reg   <= '0;
          tcnt_reg  <= '0;
          move_code <= CODE_STOPPED;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
